// File: rtl/ukp_outr_sched.sv
// Output-report scheduler: buffers one report per requester, arbitrates round-robin,
// drives the ukp request strobe and waits for ack with timeout/disconnect abort.
module ukp_outr_sched #(
  parameter int TMO_W      = 16,
  parameter int TIMEOUT    = 60000,
  parameter int GAP_CYCLES = 12
) (
  input  logic        usbclk,
  input  logic        usbrst,
  input  logic        req0_valid,
  input  logic [23:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_data,
  output logic        req1_ready,
  input  logic        connected,
  output logic        req_branch_stb,
  input  logic        ack_req_branch_stb,
  output logic [7:0]  outr0,
  output logic [7:0]  outr1,
  output logic [7:0]  outr2,
  output logic        busy,
  output logic        done_stb,
  output logic        err_stb,
  output logic        evt_src,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

  state_t             state, state_nx;
  logic               pend0, pend1, pend0_nx, pend1_nx;
  logic               last, last_nx, cur, cur_nx, grant;
  logic [23:0]        buf0, buf1, outr_q, outr_nx;
  logic [TMO_W-1:0]   cnt, cnt_nx;
  logic               stb_nx, done_nx, err_nx, evt_nx;
  logic [1:0]         code_nx;

  assign req0_ready = ~pend0;
  assign req1_ready = ~pend1;
  assign busy       = (state != IDLE);
  assign outr0      = outr_q[7:0];
  assign outr1      = outr_q[15:8];
  assign outr2      = outr_q[23:16];

  always_ff @(posedge usbclk) begin
    if (req0_valid && !pend0) buf0 <= req0_data;
    if (req1_valid && !pend1) buf1 <= req1_data;
  end

  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      state          <= IDLE;
      pend0          <= 1'b0;
      pend1          <= 1'b0;
      last           <= 1'b1;
      cur            <= 1'b0;
      cnt            <= '0;
      outr_q         <= '0;
      req_branch_stb <= 1'b0;
      done_stb       <= 1'b0;
      err_stb        <= 1'b0;
      evt_src        <= 1'b0;
      err_code       <= '0;
    end else begin
      state          <= state_nx;
      pend0          <= pend0_nx;
      pend1          <= pend1_nx;
      last           <= last_nx;
      cur            <= cur_nx;
      cnt            <= cnt_nx;
      outr_q         <= outr_nx;
      req_branch_stb <= stb_nx;
      done_stb       <= done_nx;
      err_stb        <= err_nx;
      evt_src        <= evt_nx;
      err_code       <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pend0_nx = pend0;
    pend1_nx = pend1;
    last_nx  = last;
    cur_nx   = cur;
    cnt_nx   = cnt;
    outr_nx  = outr_q;
    stb_nx   = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    evt_nx   = evt_src;
    code_nx  = err_code;
    grant    = 1'b0;

    if (req0_valid && !pend0) pend0_nx = 1'b1;
    if (req1_valid && !pend1) pend1_nx = 1'b1;

    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          if (connected) begin
            grant    = (pend0 && pend1) ? ~last : pend1;
            outr_nx  = grant ? buf1 : buf0;
            cur_nx   = grant;
            state_nx = ISSUE;
          end else if (!err_stb) begin
            // Flush spaced out so err_stb never stays high on back-to-back cycles.
            err_nx  = 1'b1;
            code_nx = 2'b10;
            if (pend0) begin
              pend0_nx = 1'b0;
              evt_nx   = 1'b0;
            end else begin
              pend1_nx = 1'b0;
              evt_nx   = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        stb_nx   = 1'b1;
        cnt_nx   = '0;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_req_branch_stb || !connected || cnt == TMO_W'(TIMEOUT - 1)) begin
          if (cur) pend1_nx = 1'b0;
          else     pend0_nx = 1'b0;
          evt_nx = cur;
          if (ack_req_branch_stb) begin
            done_nx  = 1'b1;
            last_nx  = cur;
            cnt_nx   = '0;
            state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            err_nx   = 1'b1;
            code_nx  = connected ? 2'b01 : 2'b10;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == TMO_W'(GAP_CYCLES - 1)) state_nx = IDLE;
        else                               cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ukp_outr_sched.sv
// Directed bench for ukp_outr_sched: latency, round-robin, timeout, disconnect, reset abort.
module tb_ukp_outr_sched;

  logic        usbclk = 1'b0;
  logic        usbrst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_data, req1_data;
  logic        connected, req_branch_stb, ack_req_branch_stb;
  logic [7:0]  outr0, outr1, outr2;
  logic        busy, done_stb, err_stb, evt_src;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  ukp_outr_sched #(
    .TMO_W(16),
    .TIMEOUT(16),
    .GAP_CYCLES(12)
  ) dut (
    .usbclk(usbclk), .usbrst(usbrst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .connected(connected), .req_branch_stb(req_branch_stb),
    .ack_req_branch_stb(ack_req_branch_stb),
    .outr0(outr0), .outr1(outr1), .outr2(outr2),
    .busy(busy), .done_stb(done_stb), .err_stb(err_stb),
    .evt_src(evt_src), .err_code(err_code)
  );

  always #5 usbclk = ~usbclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge usbclk);
  endtask

  task automatic do_reset();
    usbrst = 1'b1;
    step(2);
    usbrst = 1'b0;
  endtask

  // Drives valid for exactly one edge; returns at the negedge after that edge.
  task automatic offer(input logic v0, input logic v1, input logic [23:0] d0, input logic [23:0] d1);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input int maxc);
    int n = 0;
    while (!req_branch_stb && n < maxc) begin
      step();
      n++;
    end
    check(tag, req_branch_stb, 1);
  endtask

  task automatic serve(input string tag, input logic src, input logic [23:0] d);
    wait_stb({tag, "_stb"}, 40);
    check({tag, "_outr"}, {outr2, outr1, outr0}, d);
    ack_req_branch_stb = 1'b1;
    step();
    ack_req_branch_stb = 1'b0;
    check({tag, "_done"}, done_stb, 1);
    check({tag, "_src"}, evt_src, src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nerr, nstb;
    logic [1:0] ev [2];
    logic [1:0] cd [2];

    usbrst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; connected = 1'b1; ack_req_branch_stb = 1'b0;
    do_reset();
    check("rst_outr", {outr2, outr1, outr0}, 0);
    check("rst_stbs", {req_branch_stb, done_stb, err_stb, busy}, 0);
    check("rst_evt", {evt_src, err_code}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 2'b11);

    // single report, exact latency and gap
    offer(1, 0, 24'h030201, 24'h0);
    check("t1_ready0", req0_ready, 0);
    check("t1_stb_n", req_branch_stb, 0);
    step();
    check("t1_outr0", outr0, 8'h01);
    check("t1_outr1", outr1, 8'h02);
    check("t1_outr2", outr2, 8'h03);
    check("t1_stb_n1", req_branch_stb, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_stb_n2", req_branch_stb, 1);
    step();
    check("t1_stb_pulse", req_branch_stb, 0);
    step(4);
    ack_req_branch_stb = 1'b1;
    step();
    ack_req_branch_stb = 1'b0;
    check("t1_done", done_stb, 1);
    check("t1_src", evt_src, 0);
    check("t1_ready_back", req0_ready, 1);
    step();
    check("t1_done_pulse", done_stb, 0);
    step(10);
    check("t1_gap11_busy", busy, 1);
    step();
    check("t1_gap12_idle", busy, 0);

    // simultaneous pair from reset: req0 first; req0 re-offered during gap loses to req1
    do_reset();
    offer(1, 1, 24'h111111, 24'h222222);
    check("t2_ready", {req0_ready, req1_ready}, 0);
    serve("t2a", 0, 24'h111111);
    offer(1, 0, 24'h333333, 24'h0);
    serve("t2b", 1, 24'h222222);
    serve("t2c", 0, 24'h333333);

    // timeout
    do_reset();
    offer(1, 0, 24'h0a0b0c, 24'h0);
    wait_stb("t3_stb", 10);
    n = 0;
    while (!err_stb && n < 40) begin
      step();
      n++;
    end
    check("t3_tmo_cycles", n, 16);
    check("t3_code", err_code, 2'b01);
    check("t3_src", evt_src, 0);
    check("t3_ready", req0_ready, 1);
    check("t3_idle", busy, 0);
    ack_req_branch_stb = 1'b1;
    step();
    ack_req_branch_stb = 1'b0;
    check("t3_stray_ack", {done_stb, err_stb, req_branch_stb}, 0);
    check("t3_code_held", err_code, 2'b01);

    // disconnect in WAIT_ACK, then flush while disconnected
    do_reset();
    offer(0, 1, 24'h0, 24'h445566);
    wait_stb("t4_stb", 10);
    step();
    connected = 1'b0;
    step();
    check("t4_err", err_stb, 1);
    check("t4_code", err_code, 2'b10);
    check("t4_src", evt_src, 1);
    offer(1, 1, 24'h777777, 24'h888888);
    nerr = 0; nstb = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_branch_stb) nstb++;
      if (err_stb) begin
        if (nerr < 2) begin
          ev[nerr] = {1'b0, evt_src};
          cd[nerr] = err_code;
        end
        nerr++;
      end
      step();
    end
    check("t4_flush_count", nerr, 2);
    check("t4_no_stb", nstb, 0);
    check("t4_flush_first", ev[0], 0);
    check("t4_flush_second", ev[1], 1);
    check("t4_flush_codes", {cd[0], cd[1]}, 4'b1010);
    check("t4_ready", {req0_ready, req1_ready}, 2'b11);
    connected = 1'b1;

    // ack coinciding with disconnect counts as success
    do_reset();
    offer(0, 1, 24'h0, 24'h0c0b0a);
    wait_stb("t5_stb", 10);
    step(2);
    ack_req_branch_stb = 1'b1;
    connected = 1'b0;
    step();
    ack_req_branch_stb = 1'b0;
    check("t5_done", done_stb, 1);
    check("t5_noerr", err_stb, 0);
    check("t5_src", evt_src, 1);
    step();
    check("t5_noerr_after", err_stb, 0);
    connected = 1'b1;

    // reset in WAIT_ACK
    do_reset();
    offer(1, 0, 24'h123456, 24'h0);
    wait_stb("t6_stb", 10);
    step();
    usbrst = 1'b1;
    step();
    usbrst = 1'b0;
    check("t6_outr", {outr2, outr1, outr0}, 0);
    check("t6_stbs", {req_branch_stb, done_stb, err_stb, busy}, 0);
    check("t6_evt", {evt_src, err_code}, 0);
    check("t6_ready", {req0_ready, req1_ready}, 2'b11);
    ack_req_branch_stb = 1'b1;
    step();
    ack_req_branch_stb = 1'b0;
    check("t6_no_done", {done_stb, err_stb}, 0);
    step(3);
    check("t6_no_reissue", {req_branch_stb, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
